// File: rtl/trdmac_apb_driver.sv
// APB initiator that programs one TRDMAC transpose job, launches it and polls DMA_STATUS for done.
// Optional TRDMAC_DRV_TIMEOUT_EN bounds status polling to POLL_MAX reads (err=1 on expiry).
module trdmac_apb_driver #(
  parameter int unsigned POLL_GAP = 4,
  parameter int unsigned POLL_MAX = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_src_i,
  input  logic [31:0] req_dst_i,
  input  logic [5:0]  req_width_i,
  output logic        rsp_valid_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic [11:0] paddr_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  input  logic        pready_i,
  input  logic [31:0] prdata_i,
  input  logic        pslverr_i
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, GAP, DONE} state_t;

  state_t      state;
  logic [2:0]  step;
  logic [31:0] src_q;
  logic [31:0] dst_q;
  logic [5:0]  width_q;
  logic [7:0]  gap_cnt;
  logic        handshake;
  logic        poll_last;
  logic [2:0]  step_nxt;

  assign req_ready_o = (state == IDLE);
  assign handshake   = req_valid_i & req_ready_o;
  assign step_nxt    = step + 3'd1;

  function automatic logic [11:0] addr_for(input logic [2:0] s);
    return 12'h100 + {7'd0, s, 2'b00};
  endfunction

  function automatic logic [31:0] wdata_for(input logic [2:0] s, input logic [31:0] src,
                                            input logic [31:0] dst, input logic [5:0] width);
    case (s)
      3'd0:    return src;
      3'd1:    return dst;
      3'd2:    return {26'd0, width};
      default: return 32'h1;
    endcase
  endfunction

`ifdef TRDMAC_DRV_TIMEOUT_EN
  localparam int unsigned PW = $clog2(POLL_MAX + 1);

  logic [PW-1:0] poll_cnt;
  logic          unused_bits;

  assign unused_bits = ^prdata_i[31:1];
  assign poll_last   = (poll_cnt == PW'(POLL_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_cnt <= '0;
    end else if (handshake) begin
      poll_cnt <= '0;
    end else if (state == ACCESS && pready_i && step == 3'd4) begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end
`else
  logic unused_bits;

  assign unused_bits = (^prdata_i[31:1]) ^ (POLL_MAX == 0);
  assign poll_last   = 1'b0;
`endif

  // APB outputs are registered, so each transition loads the values of the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      step        <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      width_q     <= '0;
      gap_cnt     <= '0;
      psel_o      <= 1'b0;
      penable_o   <= 1'b0;
      paddr_o     <= '0;
      pwrite_o    <= 1'b0;
      pwdata_o    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            src_q     <= req_src_i;
            dst_q     <= req_dst_i;
            width_q   <= req_width_i;
            step      <= '0;
            busy_o    <= 1'b1;
            psel_o    <= 1'b1;
            penable_o <= 1'b0;
            paddr_o   <= addr_for(3'd0);
            pwrite_o  <= 1'b1;
            pwdata_o  <= req_src_i;
            state     <= SETUP;
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (pready_i) begin
            if (pslverr_i || (step == 3'd4 && !prdata_i[0] && poll_last)) begin
              psel_o      <= 1'b0;
              penable_o   <= 1'b0;
              pwrite_o    <= 1'b0;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              state       <= DONE;
            end else if (step < 3'd3) begin
              step      <= step_nxt;
              penable_o <= 1'b0;
              paddr_o   <= addr_for(step_nxt);
              pwrite_o  <= 1'b1;
              pwdata_o  <= wdata_for(step_nxt, src_q, dst_q, width_q);
              state     <= SETUP;
            end else if (step == 3'd4 && prdata_i[0]) begin
              psel_o      <= 1'b0;
              penable_o   <= 1'b0;
              pwrite_o    <= 1'b0;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b0;
              state       <= DONE;
            end else begin
              step      <= 3'd4;
              psel_o    <= 1'b0;
              penable_o <= 1'b0;
              pwrite_o  <= 1'b0;
              gap_cnt   <= 8'(POLL_GAP - 1);
              state     <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 8'd0) begin
            psel_o    <= 1'b1;
            penable_o <= 1'b0;
            paddr_o   <= addr_for(3'd4);
            pwrite_o  <= 1'b0;
            state     <= SETUP;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        DONE: begin
          rsp_valid_o <= 1'b0;
          rsp_err_o   <= 1'b0;
          busy_o      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/trdmac_apb_driver.md
Name: trdmac_apb_driver

Overview:
APB initiator that programs and launches one transpose-DMA job over the TRDMAC configuration APB port. It accepts a job descriptor (src, dst, width) on a valid/ready interface and writes SRC_ADDR, DST_ADDR, MAT_WIDTH and DMA_CMD. It then polls DMA_STATUS until the done bit is set and returns a one-cycle response. It sits between a host-side controller or test sequencer and the TRDMAC APB slave.

Parameters:
POLL_GAP, 4, idle cycles (psel=0) before each status read; legal range 1..255
POLL_MAX, 1024, maximum status reads before timeout; used only with TRDMAC_DRV_TIMEOUT_EN

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
req_valid_i  input  1  job request valid
req_ready_o  output  1  driver idle and able to accept a job
req_src_i  input  32  source address
req_dst_i  input  32  destination address
req_width_i  input  6  matrix width
rsp_valid_o  output  1  one-cycle pulse when the job finishes
rsp_err_o  output  1  qualified by rsp_valid_o; 1 = pslverr or timeout
busy_o  output  1  job in progress (state != IDLE)
psel_o  output  1  APB select
penable_o  output  1  APB enable
paddr_o  output  12  APB address
pwrite_o  output  1  APB direction
pwdata_o  output  32  APB write data
pready_i  input  1  APB ready
prdata_i  input  32  APB read data
pslverr_i  input  1  APB slave error

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset values: psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o and busy_o are 0; paddr_o and pwdata_o are 0. req_ready_o=1 (combinational, = state==IDLE). State is IDLE, step is 0.
- Reset mid-transfer forces all APB outputs to 0 immediately, with no completion of the transfer and no rsp pulse.
- States: IDLE, SETUP, ACCESS, GAP, DONE. Step counter (3 bits) selects the transfer:
  0: write 0x100 = src
  1: write 0x104 = dst
  2: write 0x108 = {26'd0, width}
  3: write 0x10C = 32'h1
  4: read 0x110
- Operands are latched on req_valid_i & req_ready_o.
- IDLE: on handshake, latch operands, step=0, go to SETUP. Input changes after the handshake are ignored.
- SETUP (1 cycle): psel=1, penable=0; paddr, pwrite and pwdata driven from step. Next state is ACCESS.
- ACCESS: psel=1, penable=1. Hold all APB outputs stable while pready_i=0; wait states are unbounded.
- On pready_i=1:
  - pslverr_i=1: go to DONE with err=1; remaining steps are skipped.
  - step<3: step+1, go straight to SETUP (back-to-back, no idle cycle).
  - step==3: step=4, go to GAP.
  - step==4 and prdata_i[0]=1: go to DONE with err=0.
  - step==4 and prdata_i[0]=0: go to GAP.
- GAP: psel=0, penable=0; count POLL_GAP cycles, then go to SETUP.
- The gap before the first status read is mandatory so a stale done from a previous job is not sampled.
- DONE (1 cycle): rsp_valid_o=1, rsp_err_o=err. Next state is IDLE; a new handshake is possible on the following cycle.
- Outside ACCESS, pready_i, pslverr_i and prdata_i are ignored.
- Latency with a zero-wait slave and done on the first poll: handshake at cycle 0; SETUP cycles at 1, 3, 5, 7; GAP at 9..8+POLL_GAP; status SETUP at 9+POLL_GAP; rsp_valid at 11+POLL_GAP.
- paddr and pwdata keep their last values while psel=0 (no toggling). pwrite=0 outside writes.

Optional Feature:
- Macro TRDMAC_DRV_TIMEOUT_EN.
- Defined: a counter (clog2(POLL_MAX+1) bits) counts status reads and resets on each handshake. If the POLL_MAX-th read returns done=0, go to DONE with err=1 instead of GAP.
- Undefined: the counter logic is absent, polling continues indefinitely, and rsp_err_o comes only from pslverr.

Test Plan:
1. Zero-wait slave; src=0x0000_1000, dst=0x0000_2000, width=16; status returns 1 -> exact writes 0x100=0x1000, 0x104=0x2000, 0x108=0x10, 0x10C=0x1, then one read of 0x110; rsp_valid at cycle 11+POLL_GAP with err=0.
2. Slave inserts 3 wait states on the 0x104 write -> ACCESS lasts 4 cycles with paddr/pwdata/psel/penable stable; response delayed exactly 3 cycles versus test 1.
3. pslverr=1 on the 0x108 write -> no 0x10C write and no status read; rsp_valid=1 with err=1 one cycle after that ACCESS; req_ready=1 next cycle.
4. Status returns 0,0,0,1 -> 4 reads of 0x110, each preceded by exactly POLL_GAP cycles with psel=0; err=0.
5. rst_n asserted mid-ACCESS of the 0x100 write -> psel/penable drop asynchronously and no rsp pulse occurs; after release, a new job completes normally.
6. With TRDMAC_DRV_TIMEOUT_EN and POLL_MAX=8, status stuck at 0 -> exactly 8 reads, then rsp_valid with err=1. Without the macro, polling is still active after 100 reads.
